// File: rtl/lab_scan_pkg.sv
// -----------------------------------------------------------------------------
// lab_scan_pkg
//   Shared definitions for the truth-table scanner:
//     - scan_state_t : FSM states IDLE / SETTLE / DONE
//     - MAX_NUM_IN   : largest supported number of swept inputs
//     - MAX_SETTLE   : largest supported settle time per vector (cycles)
//     - CNT_W        : width of the settle counter, sized for MAX_SETTLE
// -----------------------------------------------------------------------------
package lab_scan_pkg;

  localparam int MAX_NUM_IN = 4;
  localparam int MAX_SETTLE = 15;
  localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } scan_state_t;

endpackage : lab_scan_pkg

// File: rtl/lab_popcount.sv
// -----------------------------------------------------------------------------
// lab_popcount
//   Purely combinational population count.
//   Ports:
//     i_bits  [WIDTH-1:0]           : vector to count
//     o_count [$clog2(WIDTH+1)-1:0] : number of ones in i_bits
// -----------------------------------------------------------------------------
module lab_popcount #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]             i_bits,
  output logic [$clog2(WIDTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(WIDTH + 1);

  // NOTE: a combinational block assigns a default before any conditional or
  // looped update, so no path leaves o_count unassigned and no latch appears.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule : lab_popcount

// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//   Sweeps every input combination of a small combinational stage, holds each
//   vector for SETTLE_CYCLES clocks, samples the stage output into a captured
//   truth table and compares it against a golden table.
//   Ports:
//     clk          : clock, all state changes on the rising edge
//     rst          : asynchronous active-high reset
//     start        : scan request (ignored while busy)
//     vec          : drives the stage inputs; vec[NUM_IN-1] is the first input
//     dut_out      : stage output
//     exp_table    : golden table, bit i = expected output for vec == i
//     table_q      : captured table, bit i = dut_out sampled with vec == i
//     busy         : high while a scan is in progress
//     done         : one-cycle pulse when table_q/match/mismatch_cnt are valid
//     match        : table_q == exp_table, registered on entry to DONE
//     mismatch_cnt : popcount(table_q ^ exp_table), registered on entry to DONE
// -----------------------------------------------------------------------------
module truth_table_scanner
  import lab_scan_pkg::*;
#(
  parameter int NUM_IN        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [NUM_IN-1:0]      vec,
  input  logic                   dut_out,
  input  logic [2**NUM_IN-1:0]   exp_table,
  output logic [2**NUM_IN-1:0]   table_q,
  output logic                   busy,
  output logic                   done,
  output logic                   match,
  output logic [NUM_IN:0]        mismatch_cnt
);

  localparam int                TBL_W    = 2 ** NUM_IN;
  localparam logic [NUM_IN-1:0] LAST_VEC = '1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  scan_state_t        r_state;
  logic [NUM_IN-1:0]  r_vec;
  logic [CNT_W-1:0]   r_cnt;
  logic [TBL_W-1:0]   r_table_q;
  logic               r_busy;
  logic               r_done;
  logic               r_match;
  logic [NUM_IN:0]    r_mismatch_cnt;

  logic [TBL_W-1:0]   w_table_final;
  logic [TBL_W-1:0]   w_diff;
  logic [NUM_IN:0]    w_mismatch_cnt;

  // The result registered on entry to DONE must include the bit sampled on
  // that very edge, which r_table_q does not hold yet. Overlay the live sample
  // at the current index. dut_out only reaches register inputs this way, never
  // an output port.
  always_comb begin
    w_table_final        = r_table_q;
    w_table_final[r_vec] = dut_out;
  end

  assign w_diff = w_table_final ^ exp_table;

  lab_popcount #(
    .WIDTH (TBL_W)
  ) u_popcount (
    .i_bits  (w_diff),
    .o_count (w_mismatch_cnt)
  );

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the captured table is a plain register bank rather than a
      // memory, so it is cleared along with the rest of the state.
      r_state        <= IDLE;
      r_vec          <= '0;
      r_cnt          <= '0;
      r_table_q      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_match        <= 1'b0;
      r_mismatch_cnt <= '0;
    end else begin
      // done is a pulse; it is only re-armed on the edge that enters DONE.
      r_done <= 1'b0;

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= SETTLE;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_state <= IDLE;
          end
        end

        // start is deliberately not looked at here: requests while busy drop.
        SETTLE: begin
          if (r_cnt == '0) begin
            r_table_q[r_vec] <= dut_out;
            if (r_vec != LAST_VEC) begin
              r_vec <= r_vec + 1'b1;
              r_cnt <= CNT_LOAD;
            end else begin
              // vec stays at LAST_VEC until the next scan starts.
              r_state        <= DONE;
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_match        <= (w_diff == '0);
              r_mismatch_cnt <= w_mismatch_cnt;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec          = r_vec;
  assign table_q      = r_table_q;
  assign busy         = r_busy;
  assign done         = r_done;
  assign match        = r_match;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule : truth_table_scanner

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
//   Two scanner instances:
//     u_dut_a : NUM_IN=3, SETTLE_CYCLES=2, stage = x | (y & z) or tied to 0
//     u_dut_b : NUM_IN=4, SETTLE_CYCLES=1, stage = vec[0]
//   Expected scan results are queued when a scan is launched; one monitor per
//   instance pops and compares whenever that instance pulses done.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] tbl;
    logic        m;
    int          mm;
    int          busy_cycles;
  } exp_t;

  logic clk;

  // instance A
  logic        rst_a, start_a, dut_out_a, zero_mode;
  logic [2:0]  vec_a;
  logic [7:0]  exp_a, tq_a;
  logic        busy_a, done_a, match_a;
  logic [3:0]  mm_a;

  // instance B
  logic        rst_b, start_b, dut_out_b;
  logic [3:0]  vec_b;
  logic [15:0] exp_b, tq_b;
  logic        busy_b, done_b, match_b;
  logic [4:0]  mm_b;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int n_checks = 0;
  int n_errors = 0;

  // Stage A: lab2_2 with vec[2]=x, vec[1]=y, vec[0]=z, out = x | (y & z).
  assign dut_out_a = zero_mode ? 1'b0 : (vec_a[2] | (vec_a[1] & vec_a[0]));
  assign dut_out_b = vec_b[0];

  truth_table_scanner #(
    .NUM_IN        (3),
    .SETTLE_CYCLES (2)
  ) u_dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .start        (start_a),
    .vec          (vec_a),
    .dut_out      (dut_out_a),
    .exp_table    (exp_a),
    .table_q      (tq_a),
    .busy         (busy_a),
    .done         (done_a),
    .match        (match_a),
    .mismatch_cnt (mm_a)
  );

  truth_table_scanner #(
    .NUM_IN        (4),
    .SETTLE_CYCLES (1)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .start        (start_b),
    .vec          (vec_b),
    .dut_out      (dut_out_b),
    .exp_table    (exp_b),
    .table_q      (tq_b),
    .busy         (busy_b),
    .done         (done_b),
    .match        (match_b),
    .mismatch_cnt (mm_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_item(input string tag, input exp_t e, input logic [15:0] tq,
                              input logic m, input int mm, input int bc, input logic b);
    check({tag, "_table_q"},      32'(tq), 32'(e.tbl));
    check({tag, "_match"},        32'(m),  32'(e.m));
    check({tag, "_mismatch_cnt"}, mm,      e.mm);
    check({tag, "_busy_cycles"},  bc,      e.busy_cycles);
    check({tag, "_busy_at_done"}, 32'(b),  32'd0);
  endtask

  // Monitor A: counts busy cycles per scan and checks every done pulse.
  initial begin
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        bcnt = 0;
      end else if (done_a) begin
        if (sb_a.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL a_unexpected_done: done=1 with no scan outstanding");
        end else begin
          e = sb_a.pop_front();
          compare_item("a", e, {8'h00, tq_a}, match_a, int'(mm_a), bcnt, busy_a);
        end
        bcnt = 0;
      end else if (busy_a) begin
        bcnt++;
      end
    end
  end

  // Monitor B
  initial begin
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        bcnt = 0;
      end else if (done_b) begin
        if (sb_b.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL b_unexpected_done: done=1 with no scan outstanding");
        end else begin
          e = sb_b.pop_front();
          compare_item("b", e, tq_b, match_b, int'(mm_b), bcnt, busy_b);
        end
        bcnt = 0;
      end else if (busy_b) begin
        bcnt++;
      end
    end
  end

  task automatic push_a(input logic [7:0] tbl, input logic m, input int mm);
    exp_t e;
    e.tbl = {8'h00, tbl};
    e.m = m;
    e.mm = mm;
    e.busy_cycles = 16;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input logic [15:0] tbl, input logic m, input int mm);
    exp_t e;
    e.tbl = tbl;
    e.m = m;
    e.mm = mm;
    e.busy_cycles = 16;
    sb_b.push_back(e);
  endtask

  // Inputs change at a falling edge and are sampled on the following rise.
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb_a.size() == 0) break;
    end
    check("a_drain_pending", sb_a.size(), 0);
    sb_a.delete();
  endtask

  task automatic drain_b(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb_b.size() == 0) break;
    end
    check("b_drain_pending", sb_b.size(), 0);
    sb_b.delete();
  endtask

  initial begin
    zero_mode = 1'b0;
    exp_a     = 8'hF8;
    exp_b     = 16'hAAAA;
    start_a   = 1'b0;
    start_b   = 1'b0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("a_rst_vec",     32'(vec_a),  32'd0);
    check("a_rst_table_q", 32'(tq_a),   32'd0);
    check("a_rst_busy",    32'(busy_a), 32'd0);
    check("a_rst_done",    32'(done_a), 32'd0);
    check("a_rst_match",   32'(match_a),32'd0);
    check("a_rst_mm",      32'(mm_a),   32'd0);
    check("b_rst_table_q", 32'(tq_b),   32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // No start -> stays idle
    repeat (3) @(negedge clk);
    check("a_idle_busy", 32'(busy_a), 32'd0);
    check("a_idle_vec",  32'(vec_a),  32'd0);

    // Scan 1: lab2_2 vs F8, with a stray start at busy cycle 5
    push_a(8'hF8, 1'b1, 0);
    pulse_start_a();
    check("a_busy_after_start", 32'(busy_a), 32'd1);
    repeat (4) @(negedge clk);
    pulse_start_a();
    drain_a(40);

    // Results and vec held while idle
    repeat (3) @(negedge clk);
    check("a_hold_table_q", 32'(tq_a),    32'hF8);
    check("a_hold_match",   32'(match_a), 32'd1);
    check("a_hold_vec",     32'(vec_a),   32'd7);
    check("a_hold_busy",    32'(busy_a),  32'd0);
    check("a_hold_done",    32'(done_a),  32'd0);

    // Stage tied low: five golden ones missed
    zero_mode = 1'b1;
    push_a(8'h00, 1'b0, 5);
    pulse_start_a();
    drain_a(40);
    zero_mode = 1'b0;

    // Every bit disagrees: mismatch count at its maximum of 8
    exp_a = 8'h07;
    push_a(8'hF8, 1'b0, 8);
    pulse_start_a();
    drain_a(40);

    // F8 ^ 0F = F7 -> 7 mismatches
    exp_a = 8'h0F;
    push_a(8'hF8, 1'b0, 7);
    pulse_start_a();
    drain_a(40);

    // Reset in the middle of a scan, asserted away from any clock edge
    exp_a = 8'hF8;
    push_a(8'hF8, 1'b1, 0);
    pulse_start_a();
    for (int i = 0; i < 40; i++) begin
      if (vec_a == 3'd3) break;
      @(negedge clk);
    end
    check("a_reached_vec3", 32'(vec_a), 32'd3);
    #2 rst_a = 1'b1;
    #1;
    check("a_midrst_vec",     32'(vec_a),   32'd0);
    check("a_midrst_table_q", 32'(tq_a),    32'd0);
    check("a_midrst_busy",    32'(busy_a),  32'd0);
    check("a_midrst_done",    32'(done_a),  32'd0);
    check("a_midrst_match",   32'(match_a), 32'd0);
    check("a_midrst_mm",      32'(mm_a),    32'd0);
    sb_a.delete();
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (20) @(negedge clk);
    check("a_postrst_busy", 32'(busy_a), 32'd0);
    check("a_postrst_vec",  32'(vec_a),  32'd0);

    // Fresh full scan after the abandoned one
    push_a(8'hF8, 1'b1, 0);
    pulse_start_a();
    drain_a(40);

    // start held high: back-to-back scans with a single DONE cycle between
    push_a(8'hF8, 1'b1, 0);
    push_a(8'hF8, 1'b1, 0);
    start_a = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a) break;
    end
    check("a_b2b_first_done", 32'(done_a), 32'd1);
    @(negedge clk);
    check("a_b2b_restart_busy", 32'(busy_a), 32'd1);
    check("a_b2b_restart_vec",  32'(vec_a),  32'd0);
    start_a = 1'b0;
    drain_a(60);
    repeat (2) @(negedge clk);
    check("a_b2b_final_busy", 32'(busy_a), 32'd0);

    // Instance B: four inputs, one settle cycle, stage = vec[0]
    push_b(16'hAAAA, 1'b1, 0);
    pulse_start_b();
    drain_b(40);
    check("b_hold_vec", 32'(vec_b), 32'hF);

    exp_b = 16'h5555;
    push_b(16'hAAAA, 1'b0, 16);
    pulse_start_b();
    drain_b(40);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_truth_table_scanner
